// File: rtl/lock_pkg.sv
// Shared types and constants for the keypad door-lock sequencer.
// State encoding is visible on the state output and consumed by the display logic.
// Key constants map the encoder's 5-bit key index onto command keys.
package lock_pkg;

    typedef enum logic [2:0] {
        SETUP   = 3'd0,
        IDLE    = 3'd1,
        ENTRY   = 3'd2,
        CHECK   = 3'd3,
        OPEN    = 3'd4,
        LOCKOUT = 3'd5
    } state_e;

    localparam logic [4:0] KEY_ENTER  = 5'd16;
    localparam logic [4:0] KEY_CLEAR  = 5'd17;
    localparam logic [4:0] KEY_ENROLL = 5'd18;

    // Digit keys occupy indices 0..15.
    function automatic logic is_digit(input logic [4:0] k);
        return (k[4] == 1'b0);
    endfunction

endpackage

// File: rtl/dwell_timer.sv
// Loadable down-counter used for the OPEN and LOCKOUT dwell phases.
// Latency: load visible next cycle; done_o is decoded from the count register.
// Backpressure: none; counts whenever count_i is high and the count is non-zero.
//
// Ports: clk, rst_n (async active-low), load_i/load_val_i (load has priority),
//        count_i (decrement enable), done_o (count register equals 1).
module dwell_timer #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         load_i,
    input  logic [W-1:0] load_val_i,
    input  logic         count_i,
    output logic         done_o
);

    logic [W-1:0] cnt_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else if (load_i) begin
            cnt_q <= load_val_i;
        end else if (count_i && (cnt_q != '0)) begin
            cnt_q <= cnt_q - W'(1);
        end
    end

    // The owning state leaves on the edge after the count reaches 1, so a
    // load of N gives exactly N cycles in that state.
    assign done_o = (cnt_q == W'(1));

endmodule

// File: rtl/lock_sequencer.sv
// Keypad door-lock sequencer: enrol, entry, verify, timed unlock and lockout.
// Latency: a press sampled in cycle n updates state/registers in cycle n+1.
// Backpressure: none; one event per key press, keys ignored where the state does not accept them.
//
// Ports: clk, rst_n (async active-low); key_valid/key_code from the synchronized
//        keypad; state, code_out, entry, digit_cnt, fail_cnt, unlock, alarm
//        toward the display logic (all registered or decoded from registered state).
import lock_pkg::*;

module lock_sequencer #(
    parameter int DIGITS      = 8,
    parameter int MAX_FAIL    = 3,
    parameter int OPEN_CYCLES = 500,
    parameter int LOCK_CYCLES = 3000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        key_valid,
    input  logic [4:0]  key_code,
    output logic [2:0]  state,
    output logic [31:0] code_out,
    output logic [31:0] entry,
    output logic [3:0]  digit_cnt,
    output logic [1:0]  fail_cnt,
    output logic        unlock,
    output logic        alarm
);

    localparam int MAX_CYC = (OPEN_CYCLES > LOCK_CYCLES) ? OPEN_CYCLES : LOCK_CYCLES;
    localparam int TW      = $clog2(MAX_CYC + 1);

    state_e         state_q, state_d;
    logic [31:0]    code_q, code_d;
    logic [31:0]    entry_q, entry_d;
    logic [3:0]     cnt_q, cnt_d;
    logic [1:0]     fail_q, fail_d;
    logic           key_prev_q;

    logic           press;
    logic           tmr_load;
    logic [TW-1:0]  tmr_load_val;
    logic           tmr_count;
    logic           tmr_done;

    // One event per key press: rising edge of the (already synchronized) level.
    assign press = key_valid && !key_prev_q;

    assign tmr_count = (state_q == OPEN) || (state_q == LOCKOUT);

    dwell_timer #(.W(TW)) u_dwell_timer (
        .clk        (clk),
        .rst_n      (rst_n),
        .load_i     (tmr_load),
        .load_val_i (tmr_load_val),
        .count_i    (tmr_count),
        .done_o     (tmr_done)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= SETUP;
            code_q     <= '0;
            entry_q    <= '0;
            cnt_q      <= '0;
            fail_q     <= '0;
            key_prev_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            code_q     <= code_d;
            entry_q    <= entry_d;
            cnt_q      <= cnt_d;
            fail_q     <= fail_d;
            key_prev_q <= key_valid;
        end
    end

    always_comb begin
        logic digit_ev;
        logic full;

        state_d      = state_q;
        code_d       = code_q;
        entry_d      = entry_q;
        cnt_d        = cnt_q;
        fail_d       = fail_q;
        tmr_load     = 1'b0;
        tmr_load_val = '0;

        digit_ev = press && is_digit(key_code);
        full     = (cnt_q == 4'(DIGITS));

        unique case (state_q)
            SETUP: begin
                if (digit_ev && !full) begin
                    entry_d = {entry_q[27:0], key_code[3:0]};
                    cnt_d   = cnt_q + 4'd1;
                end else if (press && key_code == KEY_CLEAR) begin
                    entry_d = '0;
                    cnt_d   = '0;
                end else if (press && key_code == KEY_ENTER && full) begin
                    code_d  = entry_q;
                    entry_d = '0;
                    cnt_d   = '0;
                    state_d = IDLE;
                end
            end

            IDLE: begin
                if (digit_ev) begin
                    entry_d = {entry_q[27:0], key_code[3:0]};
                    cnt_d   = cnt_q + 4'd1;
                    state_d = ENTRY;
                end
            end

            ENTRY: begin
                if (digit_ev && !full) begin
                    entry_d = {entry_q[27:0], key_code[3:0]};
                    cnt_d   = cnt_q + 4'd1;
                end else if (press && key_code == KEY_CLEAR) begin
                    entry_d = '0;
                    cnt_d   = '0;
                    state_d = IDLE;
                end else if (press && key_code == KEY_ENTER) begin
                    state_d = CHECK;
                end
            end

            CHECK: begin
                entry_d = '0;
                cnt_d   = '0;
                if ((entry_q == code_q) && full) begin
                    fail_d       = '0;
                    state_d      = OPEN;
                    tmr_load     = 1'b1;
                    tmr_load_val = TW'(OPEN_CYCLES);
                end else if ((3'({1'b0, fail_q}) + 3'd1) == 3'(MAX_FAIL)) begin
                    state_d      = LOCKOUT;
                    tmr_load     = 1'b1;
                    tmr_load_val = TW'(LOCK_CYCLES);
                end else begin
                    fail_d  = fail_q + 2'd1;
                    state_d = IDLE;
                end
            end

            OPEN: begin
                // Expiry takes precedence; a key arriving on that cycle is dropped.
                if (tmr_done) begin
                    state_d = IDLE;
                end else if (press && key_code == KEY_ENTER) begin
                    state_d = IDLE;
                end else if (press && key_code == KEY_ENROLL) begin
                    // Old code stays live until the new one is committed.
                    entry_d = '0;
                    cnt_d   = '0;
                    state_d = SETUP;
                end
            end

            LOCKOUT: begin
                if (tmr_done) begin
                    fail_d  = '0;
                    state_d = IDLE;
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign state     = state_q;
    assign code_out  = code_q;
    assign entry     = entry_q;
    assign digit_cnt = cnt_q;
    assign fail_cnt  = fail_q;
    assign unlock    = (state_q == OPEN);
    assign alarm     = (state_q == LOCKOUT);

endmodule

// File: tb/tb_lock_sequencer.sv
// Directed testbench for lock_sequencer with DIGITS=4, MAX_FAIL=3, OPEN=5, LOCK=8.
// Inputs change 1 time unit after the rising edge; outputs are sampled there too.
// Each check goes through chk(); summary line reports compared / mismatched.
module tb_lock_sequencer;
    import lock_pkg::*;

    logic        clk;
    logic        rst_n;
    logic        key_valid;
    logic [4:0]  key_code;
    logic [2:0]  state;
    logic [31:0] code_out;
    logic [31:0] entry;
    logic [3:0]  digit_cnt;
    logic [1:0]  fail_cnt;
    logic        unlock;
    logic        alarm;

    int n_cmp = 0;
    int n_err = 0;

    lock_sequencer #(
        .DIGITS      (4),
        .MAX_FAIL    (3),
        .OPEN_CYCLES (5),
        .LOCK_CYCLES (8)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .key_valid (key_valid),
        .key_code  (key_code),
        .state     (state),
        .code_out  (code_out),
        .entry     (entry),
        .digit_cnt (digit_cnt),
        .fail_cnt  (fail_cnt),
        .unlock    (unlock),
        .alarm     (alarm)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Key held for 3 cycles, then released for 1.
    task automatic press(input logic [4:0] k);
        key_code  = k;
        key_valid = 1'b1;
        repeat (3) tick();
        key_valid = 1'b0;
        tick();
    endtask

    task automatic press4(input logic [4:0] a, input logic [4:0] b,
                          input logic [4:0] c, input logic [4:0] d);
        press(a); press(b); press(c); press(d);
    endtask

    // ENTER from ENTRY: CHECK next cycle, outcome the cycle after.
    task automatic enter_chk(input string tag, input logic [2:0] exp_after);
        key_code  = KEY_ENTER;
        key_valid = 1'b1;
        tick();
        chk({tag, "_check"}, 32'(state), 32'(CHECK));
        key_valid = 1'b0;
        tick();
        chk({tag, "_outcome"}, 32'(state), 32'(exp_after));
    endtask

    initial begin
        int n;
        rst_n     = 1'b0;
        key_valid = 1'b0;
        key_code  = 5'd0;
        repeat (2) tick();

        chk("rst_state",  32'(state), 32'(SETUP));
        chk("rst_code",   code_out, 32'h0);
        chk("rst_entry",  entry, 32'h0);
        chk("rst_cnt",    32'(digit_cnt), 32'd0);
        chk("rst_flags",  {29'd0, fail_cnt, unlock}, 32'd0);
        chk("rst_alarm",  32'(alarm), 32'd0);
        rst_n = 1'b1;
        tick();

        // Enrol: short ENTER ignored, then complete code.
        press(5'd1); press(5'd2); press(5'd3);
        chk("enrol_entry3", entry, 32'h123);
        press(KEY_ENTER);
        chk("enrol_short_state", 32'(state), 32'(SETUP));
        chk("enrol_short_cnt", 32'(digit_cnt), 32'd3);
        press(5'd4);
        chk("enrol_entry4", entry, 32'h1234);
        press(KEY_ENTER);
        chk("enrol_state", 32'(state), 32'(IDLE));
        chk("enrol_code", code_out, 32'h1234);
        chk("enrol_cnt", 32'(digit_cnt), 32'd0);
        chk("enrol_entry_clr", entry, 32'h0);

        // Unlock with exact OPEN duration.
        press4(5'd1, 5'd2, 5'd3, 5'd4);
        chk("unl_state_entry", 32'(state), 32'(ENTRY));
        enter_chk("unl", OPEN);
        chk("unl_flag", 32'(unlock), 32'd1);
        n = 1;
        for (int i = 0; i < 50; i++) begin
            tick();
            if (state == OPEN) n++;
            else break;
        end
        chk("unl_open_cycles", 32'(n), 32'd5);
        chk("unl_after_state", 32'(state), 32'(IDLE));
        chk("unl_after_flag", 32'(unlock), 32'd0);
        chk("unl_fail", 32'(fail_cnt), 32'd0);

        // Lockout after three wrong entries.
        press4(5'd1, 5'd2, 5'd3, 5'd5);
        enter_chk("bad1", IDLE);
        chk("bad1_fail", 32'(fail_cnt), 32'd1);
        press4(5'd1, 5'd2, 5'd3, 5'd5);
        enter_chk("bad2", IDLE);
        chk("bad2_fail", 32'(fail_cnt), 32'd2);
        press4(5'd1, 5'd2, 5'd3, 5'd5);
        enter_chk("bad3", LOCKOUT);
        chk("lock_alarm", 32'(alarm), 32'd1);
        chk("lock_unlock", 32'(unlock), 32'd0);
        n = 1;
        for (int i = 0; i < 50; i++) begin
            key_valid = ~key_valid;
            key_code  = (i % 4 == 1) ? KEY_ENTER : 5'd7;
            tick();
            if (state == LOCKOUT) n++;
            else break;
        end
        key_valid = 1'b0;
        chk("lock_cycles", 32'(n), 32'd8);
        chk("lock_after_state", 32'(state), 32'(IDLE));
        chk("lock_after_fail", 32'(fail_cnt), 32'd0);
        chk("lock_keys_ignored", {28'd0, digit_cnt}, 32'd0);
        chk("lock_entry", entry, 32'h0);
        tick();

        // Short entry fails.
        press(5'd1); press(5'd2); press(5'd3);
        enter_chk("short", IDLE);
        chk("short_fail", 32'(fail_cnt), 32'd1);

        // Overlong entry: fifth digit dropped, still matches.
        press4(5'd1, 5'd2, 5'd3, 5'd4);
        press(5'd9);
        chk("long_entry", entry, 32'h1234);
        chk("long_cnt", 32'(digit_cnt), 32'd4);
        enter_chk("long", OPEN);
        chk("long_fail", 32'(fail_cnt), 32'd0);

        // Re-enrol from OPEN.
        press(KEY_ENROLL);
        chk("reenrol_state", 32'(state), 32'(SETUP));
        chk("reenrol_code_kept", code_out, 32'h1234);
        press4(5'd5, 5'd6, 5'd7, 5'd8);
        press(KEY_ENTER);
        chk("reenrol_code", code_out, 32'h5678);
        chk("reenrol_state_idle", 32'(state), 32'(IDLE));
        press4(5'd1, 5'd2, 5'd3, 5'd4);
        enter_chk("oldcode", IDLE);
        chk("oldcode_fail", 32'(fail_cnt), 32'd1);

        // Reset in the third OPEN cycle.
        press4(5'd5, 5'd6, 5'd7, 5'd8);
        enter_chk("newcode", OPEN);
        tick();
        tick();
        chk("mid_open", 32'(unlock), 32'd1);
        rst_n = 1'b0;
        #2;
        chk("arst_unlock", 32'(unlock), 32'd0);
        chk("arst_state", 32'(state), 32'(SETUP));
        chk("arst_code", code_out, 32'h0);
        chk("arst_entry", entry, 32'h0);
        chk("arst_cnt_fail", {26'd0, digit_cnt, fail_cnt}, 32'd0);
        tick();
        rst_n = 1'b1;
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish, got hang expected finish");
        $fatal(1);
    end

endmodule
